// File: rtl/line_sender_pkg.sv
// Shared definitions for the line_sender UART response path.
// Build option: LINE_SENDER_PARITY_EN adds an even-parity bit to every frame.
package line_sender_pkg;

    // Serialiser FSM encoding; the parity state only exists when parity is built in.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef LINE_SENDER_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_e;

`ifdef LINE_SENDER_PARITY_EN
    localparam int UART_FRAME_BITS = 11;
`else
    localparam int UART_FRAME_BITS = 10;
`endif

    localparam int   UART_DATA_BITS = 8;
    localparam int   MAX_LINE_BYTES = 4;
    localparam logic LINE_IDLE      = 1'b1;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/line_sender_uart_tx_byte.sv
// Single-frame UART serialiser: start bit, data LSB first, optional parity, stop bit.
// A new start can be taken in the last cycle of the stop bit, so back-to-back
// frames carry no idle gap. Build option: LINE_SENDER_PARITY_EN.
module uart_tx_byte
    import line_sender_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  tx,
    output logic                  ready,
    output logic                  frame_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    uart_state_e           state_r;
    uart_state_e           state_next_s;
    logic [BAUD_W-1:0]     baud_cnt_r;
    logic [BAUD_W-1:0]     baud_cnt_next_s;
    logic [BIT_W-1:0]      bit_idx_r;
    logic [BIT_W-1:0]      bit_idx_next_s;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  tx_r;
    logic                  tx_next_s;
    logic                  bit_tick_s;
    logic                  accept_s;

    assign bit_tick_s = (baud_cnt_r == BAUD_LAST);
    assign frame_done = (state_r == ST_STOP) && bit_tick_s;
    assign ready      = (state_r == ST_IDLE) || frame_done;
    assign accept_s   = start && ready;
    assign tx         = tx_r;

    // State, counters, latched byte and the registered line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= {BAUD_W{1'b0}};
            bit_idx_r  <= {BIT_W{1'b0}};
            data_r     <= {DATA_WIDTH{1'b0}};
            tx_r       <= LINE_IDLE;
        end else begin
            state_r    <= state_next_s;
            baud_cnt_r <= baud_cnt_next_s;
            bit_idx_r  <= bit_idx_next_s;
            tx_r       <= tx_next_s;
            if (accept_s) begin
                data_r <= data;
            end
        end
    end

    // Next-state decode: each bit lasts one full baud period.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_next_s = ST_START;
                else          state_next_s = ST_IDLE;
            end
            ST_START: begin
                if (bit_tick_s) state_next_s = ST_DATA;
                else            state_next_s = ST_START;
            end
            ST_DATA: begin
                if (bit_tick_s && (bit_idx_r == BIT_LAST)) begin
`ifdef LINE_SENDER_PARITY_EN
                    state_next_s = ST_PARITY;
`else
                    state_next_s = ST_STOP;
`endif
                end else begin
                    state_next_s = ST_DATA;
                end
            end
`ifdef LINE_SENDER_PARITY_EN
            ST_PARITY: begin
                if (bit_tick_s) state_next_s = ST_STOP;
                else            state_next_s = ST_PARITY;
            end
`endif
            ST_STOP: begin
                if (bit_tick_s) begin
                    if (accept_s) state_next_s = ST_START;
                    else          state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Counter updates and the line level that the next state will drive.
    always_comb begin
        baud_cnt_next_s = {BAUD_W{1'b0}};
        bit_idx_next_s  = {BIT_W{1'b0}};
        tx_next_s       = LINE_IDLE;

        if ((state_r == ST_IDLE) || bit_tick_s) baud_cnt_next_s = {BAUD_W{1'b0}};
        else                                    baud_cnt_next_s = baud_cnt_r + BAUD_W'(1);

        if (state_r == ST_DATA) begin
            if (bit_tick_s) bit_idx_next_s = bit_idx_r + BIT_W'(1);
            else            bit_idx_next_s = bit_idx_r;
        end else begin
            bit_idx_next_s = {BIT_W{1'b0}};
        end

        case (state_next_s)
            ST_START:  tx_next_s = 1'b0;
            ST_DATA:   tx_next_s = data_r[bit_idx_next_s];
`ifdef LINE_SENDER_PARITY_EN
            ST_PARITY: tx_next_s = even_parity(data_r);
`endif
            ST_STOP:   tx_next_s = 1'b1;
            ST_IDLE:   tx_next_s = LINE_IDLE;
            default:   tx_next_s = LINE_IDLE;
        endcase
    end

endmodule

// File: rtl/line_sender.sv
// Sends the 1..4 byte response word on the UART line, byte 0 first.
// Owns byte selection, count clamping, busy and the end-of-line pulse;
// framing is delegated to uart_tx_byte. Build option: LINE_SENDER_PARITY_EN.
module line_sender
    import line_sender_pkg::*;
#(
    parameter int WORD_SIZE    = 32,
    parameter int SIZE_WORD    = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_SIZE-1:0]  send_data_register,
    input  logic [SIZE_WORD-1:0]  size_line,
    input  logic                  valid_data,
    output logic                  busy_sender_data,
    output logic                  tx,
    output logic                  tx_done
);

    localparam logic [SIZE_WORD-1:0] MAX_COUNT = SIZE_WORD'(MAX_LINE_BYTES);

    logic [WORD_SIZE-1:0]  word_r;
    logic [SIZE_WORD-1:0]  count_r;
    logic [SIZE_WORD-1:0]  byte_idx_r;
    logic [SIZE_WORD-1:0]  next_idx_s;
    logic [SIZE_WORD-1:0]  clamped_s;
    logic [DATA_WIDTH-1:0] next_byte_s;
    logic [DATA_WIDTH-1:0] byte_s;
    logic                  busy_r;
    logic                  tx_done_r;
    logic                  accept_s;
    logic                  more_bytes_s;
    logic                  start_s;
    logic                  ready_s;
    logic                  frame_done_s;

    assign clamped_s    = (size_line > MAX_COUNT) ? MAX_COUNT : size_line;
    assign accept_s     = valid_data && !busy_r && ready_s && (size_line != {SIZE_WORD{1'b0}});
    assign next_idx_s   = byte_idx_r + SIZE_WORD'(1);
    assign more_bytes_s = (next_idx_s < count_r);
    assign start_s      = accept_s || (busy_r && frame_done_s && more_bytes_s);

    assign busy_sender_data = busy_r;
    assign tx_done          = tx_done_r;

    // Pick the byte that follows the one currently on the line.
    always_comb begin
        next_byte_s = word_r[0 +: DATA_WIDTH];
        case (next_idx_s)
            SIZE_WORD'(1): next_byte_s = word_r[DATA_WIDTH*1 +: DATA_WIDTH];
            SIZE_WORD'(2): next_byte_s = word_r[DATA_WIDTH*2 +: DATA_WIDTH];
            SIZE_WORD'(3): next_byte_s = word_r[DATA_WIDTH*3 +: DATA_WIDTH];
            default:       next_byte_s = word_r[0 +: DATA_WIDTH];
        endcase
        if (accept_s) byte_s = send_data_register[DATA_WIDTH-1:0];
        else          byte_s = next_byte_s;
    end

    // Line-level bookkeeping: latch the request, step bytes, end the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_r     <= {WORD_SIZE{1'b0}};
            count_r    <= {SIZE_WORD{1'b0}};
            byte_idx_r <= {SIZE_WORD{1'b0}};
            busy_r     <= 1'b0;
            tx_done_r  <= 1'b0;
        end else begin
            tx_done_r <= 1'b0;
            if (accept_s) begin
                word_r     <= send_data_register;
                count_r    <= clamped_s;
                byte_idx_r <= {SIZE_WORD{1'b0}};
                busy_r     <= 1'b1;
            end else if (busy_r && frame_done_s) begin
                if (more_bytes_s) begin
                    byte_idx_r <= next_idx_s;
                end else begin
                    busy_r    <= 1'b0;
                    tx_done_r <= 1'b1;
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_tx_byte (
        .clk        (clk),
        .rst        (rst),
        .start      (start_s),
        .data       (byte_s),
        .tx         (tx),
        .ready      (ready_s),
        .frame_done (frame_done_s)
    );

endmodule
